// File: rtl/byte_serial_subtractor.sv
// byte_serial_subtractor: computes a - b - bin one byte per clock through an 8-bit Kogge-Stone stage.
// Defining BYTE_SERIAL_SUBTRACTOR_ADD_MODE_EN adds an `op` port; op=1 selects a + b + bin.
module byte_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef BYTE_SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 8;
    localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam int IW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, b_r, diff_nx;
    logic             carry, op_in, op_r, last;
    logic [IW-1:0]    base;
    logic [7:0]       sa, sb, g, p, gn, pn, s;
    logic [8:0]       c;

`ifdef BYTE_SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    assign base = IW'({k, 3'b000});
    assign last = k == KW'(NSLICE - 1);
    assign sa   = a_r[base +: 8];
    assign sb   = op_r ? b_r[base +: 8] : ~b_r[base +: 8];

    // Prefix levels of span 1, 2, 4; the incoming carry joins only at the final gray row.
    always_comb begin
        g = sa & sb;
        p = sa ^ sb;
        gn = g;
        pn = p;
        for (int d = 1; d < 8; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < 8; i++) begin
                gn[i] = g[i] | (p[i] & g[i - d]);
                pn[i] = p[i] & p[i - d];
            end
            g = gn;
            p = pn;
        end
        c = {g | (p & {8{carry}}), carry};
        s = (sa ^ sb) ^ c[7:0];
    end

    always_comb begin
        diff_nx = diff;
        diff_nx[base +: 8] = s;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= 1'b0;
            carry <= 1'b0;
            k     <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op_in;
            carry <= bin ^ ~op_in;
            k     <= '0;
        end else if (state == RUN) begin
            diff  <= diff_nx;
            carry <= c[8];
            k     <= k + 1'b1;
            if (last) begin
                bout <= c[8] ^ ~op_r;
                zero <= diff_nx == '0;
                neg  <= s[7];
                ovf  <= (a_r[MSB] ^ b_r[MSB] ^ op_r) & (s[7] ^ a_r[MSB]);
            end
        end
    end
endmodule

// File: tb/tb_byte_serial_subtractor.sv
// tb_byte_serial_subtractor: table-driven checks of byte_serial_subtractor plus handshake and reset sequences.
module tb_byte_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, bin, op, out_valid, out_ready;
    logic        bout, zero, neg, ovf;
    logic [31:0] a, b, diff;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] a, b;
        logic        bin, op;
        logic [31:0] d;
        logic        bo, z, n, o;
    } vec_t;

    vec_t v [9];

    byte_serial_subtractor #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
`ifdef BYTE_SERIAL_SUBTRACTOR_ADD_MODE_EN
        .op(op),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic accept(input vec_t t, input int idx);
        @(negedge clk);
        a = t.a; b = t.b; bin = t.bin; op = t.op; in_valid = 1'b1;
        chk("in_ready_idle", idx, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = ~t.a; b = ~t.b; bin = ~t.bin; op = ~t.op;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input vec_t t, input int idx);
        int n;
        accept(t, idx);
        wait_done(n);
        chk("latency", idx, n, 32'd4);
        chk("diff", idx, diff, t.d);
        chk("bout", idx, {31'b0, bout}, {31'b0, t.bo});
        chk("zero", idx, {31'b0, zero}, {31'b0, t.z});
        chk("neg", idx, {31'b0, neg}, {31'b0, t.n});
        chk("ovf", idx, {31'b0, ovf}, {31'b0, t.o});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", idx, {31'b0, out_valid}, 32'd0);
        chk("in_ready_back", idx, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int   n;
        vec_t bp;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0; op = 1'b0;
        v[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        v[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        v[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        v[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        v[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        v[6] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0};
        v[7] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h4B4B_4B4B, 1'b0, 1'b0, 1'b0, 1'b1};
        v[8] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        bp   = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 32'hCC79_6877, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 0, {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", 0, {31'b0, out_valid}, 32'd0);
        chk("rst_diff", 0, diff, 32'd0);
        chk("rst_flags", 0, {28'b0, bout, zero, neg, ovf}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run(v[i], i);
`ifdef BYTE_SERIAL_SUBTRACTOR_ADD_MODE_EN
        run(v[8], 8);
`endif

        // Backpressure: result held, no accept while DONE.
        accept(bp, 100);
        wait_done(n);
        chk("bp_latency", 100, n, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'h0000_0009; b = 32'h0000_0001; bin = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_diff", i, diff, bp.d);
            chk("bp_flags", i, {28'b0, bout, zero, neg, ovf}, {28'b0, bp.bo, bp.z, bp.n, bp.o});
            chk("bp_out_valid", i, {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", i, {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 100, {31'b0, out_valid}, 32'd0);
        chk("bp_release_ready", 100, {31'b0, in_ready}, 32'd1);
        chk("bp_diff_kept", 100, diff, bp.d);

        // Reset asserted during the third slice cycle.
        accept(v[7], 200);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 200, {31'b0, out_valid}, 32'd0);
        chk("rst_mid_in_ready", 200, {31'b0, in_ready}, 32'd1);
        chk("rst_mid_diff", 200, diff, 32'd0);
        chk("rst_mid_flags", 200, {28'b0, bout, zero, neg, ovf}, 32'd0);
        #1;
        rst_n = 1'b1;
        run(v[6], 201);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
